pkt_mem_wr_ctrl: RTL and testbench

Write-side controller for the packet RAM and packet-length FIFO of the receive buffer. Sequences GMII-style receive bytes into a circular byte RAM and holds each packet as tentative until the external CRC checker gives a verdict. A good packet is committed: the write pointer advances and its length is pushed to the length FIFO. A bad packet is rolled back, so readers only ever see whole, CRC-good packets.

---
 rtl/pkt_mem_pkg.sv | 16 +
 rtl/pkt_ring_ptr.sv | 14 +
 rtl/pkt_mem_wr_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pkt_mem_wr_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_mem_pkg.sv
// rtl/pkt_mem_pkg.sv - shared FSM encoding and default sizing for the packet RAM controllers
package pkt_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT_CRC,
        ST_COMMIT,
        ST_DROP
    } state_t;

    localparam int MAX_PACKET_LENGTH = 1536;
    localparam int MIN_PACKET_LENGTH = 64;
    localparam int DEPTH_RAM         = 3072;

endpackage

// File: rtl/pkt_ring_ptr.sv
// rtl/pkt_ring_ptr.sv - circular buffer pointer increment, wraps from pDEPTH-1 to 0
module pkt_ring_ptr
    import pkt_mem_pkg::*;
#(
    parameter int pDEPTH      = DEPTH_RAM,
    parameter int pADDR_WIDTH = $clog2(pDEPTH)
) (
    input  logic [pADDR_WIDTH-1:0] i_ptr,
    output logic [pADDR_WIDTH-1:0] o_ptr_next
);

    assign o_ptr_next = (i_ptr == pADDR_WIDTH'(pDEPTH - 1)) ? '0 : i_ptr + 1'b1;

endmodule

// File: rtl/pkt_mem_wr_ctrl.sv
// rtl/pkt_mem_wr_ctrl.sv - packet RAM write controller with CRC-gated commit/rollback
// Optional PKT_WR_STATS_EN adds saturating good/bad packet counters.
module pkt_mem_wr_ctrl
    import pkt_mem_pkg::*;
#(
    parameter int pDATA_WIDTH        = 8,
    parameter int pDEPTH_RAM         = DEPTH_RAM,
    parameter int pADDR_WIDTH        = $clog2(pDEPTH_RAM),
    parameter int pLEN_WIDTH         = 16,
    parameter int pMAX_PACKET_LENGTH = MAX_PACKET_LENGTH,
    parameter int pMIN_PACKET_LENGTH = MIN_PACKET_LENGTH
) (
    input  logic                   iclk,
    input  logic                   i_rst,
    input  logic                   idv,
    input  logic [pDATA_WIDTH-1:0] irx_d,
    input  logic                   irx_er,
    input  logic                   icrc_valid,
    input  logic                   icrc_ok,
    input  logic                   ilen_full,
    input  logic                   irel,
    input  logic [pLEN_WIDTH-1:0]  irel_len,
    output logic                   oram_we,
    output logic [pADDR_WIDTH-1:0] oram_waddr,
    output logic [pDATA_WIDTH-1:0] oram_wdata,
    output logic                   olen_we,
    output logic [pLEN_WIDTH-1:0]  olen_data,
    output logic                   odrop,
`ifdef PKT_WR_STATS_EN
    output logic [15:0]            ogood_cnt,
    output logic [15:0]            obad_cnt,
`endif
    output logic [pADDR_WIDTH:0]   oused
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [pADDR_WIDTH-1:0] r_wr_ptr_succ;
    logic [pADDR_WIDTH-1:0] r_wr_ptr_now;
    logic [pADDR_WIDTH-1:0] w_ptr_inc;
    logic [pLEN_WIDTH-1:0]  r_count;
    logic [pADDR_WIDTH:0]   r_used;
    logic [pADDR_WIDTH:0]   w_free;
    logic [pADDR_WIDTH:0]   w_used_add;
    logic [pADDR_WIDTH:0]   w_used_sub;
    logic                   w_accept;
    logic                   w_space_ok;
    logic                   w_at_max;
    logic                   w_min_ok;
    logic                   r_ram_we;
    logic [pADDR_WIDTH-1:0] r_ram_waddr;
    logic [pDATA_WIDTH-1:0] r_ram_wdata;
    logic                   r_drop;
    logic                   w_unused_rel_hi;

    pkt_ring_ptr #(
        .pDEPTH      (pDEPTH_RAM),
        .pADDR_WIDTH (pADDR_WIDTH)
    ) u_ptr_inc (
        .i_ptr      (r_wr_ptr_now),
        .o_ptr_next (w_ptr_inc)
    );

    // Only one packet is ever tentative, so reserving a maximum-sized slot
    // up front guarantees its bytes never overwrite committed data.
    assign w_free     = (pADDR_WIDTH + 1)'(pDEPTH_RAM) - r_used;
    assign w_space_ok = w_free >= (pADDR_WIDTH + 1)'(pMAX_PACKET_LENGTH);
    assign w_at_max   = r_count == pLEN_WIDTH'(pMAX_PACKET_LENGTH);
    assign w_min_ok   = r_count >= pLEN_WIDTH'(pMIN_PACKET_LENGTH);

    assign w_used_add = (r_state == ST_COMMIT) ? r_count[pADDR_WIDTH:0] : '0;
    assign w_used_sub = irel ? irel_len[pADDR_WIDTH:0] : '0;
    assign w_unused_rel_hi = ^irel_len[pLEN_WIDTH-1:pADDR_WIDTH+1];

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (idv) begin
                    if (w_space_ok && !ilen_full) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_WRITE;
                    end else begin
                        w_state_next = ST_DROP;
                    end
                end
            end
            ST_WRITE: begin
                if (irx_er || (idv && w_at_max)) begin
                    w_state_next = ST_DROP;
                end else if (idv) begin
                    w_accept = 1'b1;
                end else begin
                    w_state_next = ST_WAIT_CRC;
                end
            end
            ST_WAIT_CRC: begin
                if (icrc_valid) begin
                    w_state_next = (icrc_ok && w_min_ok) ? ST_COMMIT : ST_DROP;
                end else if (idv) begin
                    w_state_next = ST_DROP;
                end
            end
            ST_COMMIT: w_state_next = ST_IDLE;
            ST_DROP: begin
                if (!idv) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_wr_ptr_succ <= '0;
            r_wr_ptr_now  <= '0;
            r_count       <= '0;
            r_used        <= '0;
            r_ram_we      <= 1'b0;
            r_ram_waddr   <= '0;
            r_ram_wdata   <= '0;
            r_drop        <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_used   <= r_used + w_used_add - w_used_sub;
            r_ram_we <= w_accept;
            r_drop   <= (w_state_next == ST_DROP) && (r_state != ST_DROP);
            if (w_accept) begin
                r_ram_waddr  <= r_wr_ptr_now;
                r_ram_wdata  <= irx_d;
                r_wr_ptr_now <= w_ptr_inc;
                r_count      <= (r_state == ST_IDLE) ? pLEN_WIDTH'(1) : r_count + 1'b1;
            end else if (r_state == ST_DROP) begin
                r_wr_ptr_now <= r_wr_ptr_succ;
            end
            if (r_state == ST_COMMIT) begin
                r_wr_ptr_succ <= r_wr_ptr_now;
            end
        end
    end

`ifdef PKT_WR_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            if ((r_state == ST_COMMIT) && (r_good_cnt != 16'hFFFF)) begin
                r_good_cnt <= r_good_cnt + 1'b1;
            end
            if (r_drop && (r_bad_cnt != 16'hFFFF)) begin
                r_bad_cnt <= r_bad_cnt + 1'b1;
            end
        end
    end

    assign ogood_cnt = r_good_cnt;
    assign obad_cnt  = r_bad_cnt;
`endif

    assign oram_we    = r_ram_we;
    assign oram_waddr = r_ram_waddr;
    assign oram_wdata = r_ram_wdata;
    assign olen_we    = (r_state == ST_COMMIT);
    assign olen_data  = (r_state == ST_COMMIT) ? r_count : '0;
    assign odrop      = r_drop;
    assign oused      = r_used;

endmodule

// File: tb/tb_pkt_mem_wr_ctrl.sv
// tb/tb_pkt_mem_wr_ctrl.sv - scoreboard bench for pkt_mem_wr_ctrl
module tb_pkt_mem_wr_ctrl;

    logic        iclk = 1'b0;
    logic        i_rst;
    logic        idv;
    logic [7:0]  irx_d;
    logic        irx_er;
    logic        icrc_valid;
    logic        icrc_ok;
    logic        ilen_full;
    logic        irel;
    logic [15:0] irel_len;
    logic        oram_we;
    logic [11:0] oram_waddr;
    logic [7:0]  oram_wdata;
    logic        olen_we;
    logic [15:0] olen_data;
    logic        odrop;
    logic [12:0] oused;

    int n_checks = 0;
    int n_errors = 0;

    logic [19:0] exp_wr_q[$];
    int          exp_len_q[$];
    int          exp_drop_q[$];

    pkt_mem_wr_ctrl dut (
        .iclk       (iclk),
        .i_rst      (i_rst),
        .idv        (idv),
        .irx_d      (irx_d),
        .irx_er     (irx_er),
        .icrc_valid (icrc_valid),
        .icrc_ok    (icrc_ok),
        .ilen_full  (ilen_full),
        .irel       (irel),
        .irel_len   (irel_len),
        .oram_we    (oram_we),
        .oram_waddr (oram_waddr),
        .oram_wdata (oram_wdata),
        .olen_we    (olen_we),
        .olen_data  (olen_data),
        .odrop      (odrop),
        .oused      (oused)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got output %0d while none expected", name, act);
    endtask

    // Monitor: pops expectations whenever the DUT presents an output.
    initial begin
        logic [19:0] e;
        forever begin
            @(posedge iclk);
            #1;
            if (!i_rst) begin
                if (oram_we) begin
                    if (exp_wr_q.size() == 0) begin
                        unexpected("ram_write", int'(oram_waddr));
                    end else begin
                        e = exp_wr_q.pop_front();
                        check("ram_waddr", int'(oram_waddr), int'(e[19:8]));
                        check("ram_wdata", int'(oram_wdata), int'(e[7:0]));
                    end
                end
                if (olen_we) begin
                    if (exp_len_q.size() == 0) unexpected("len_push", int'(olen_data));
                    else check("len_data", int'(olen_data), exp_len_q.pop_front());
                end
                if (odrop) begin
                    if (exp_drop_q.size() == 0) unexpected("drop_pulse", 1);
                    else void'(exp_drop_q.pop_front());
                end
            end
        end
    end

    function automatic logic [7:0] pat(input int seed, input int i);
        logic [31:0] v;
        v = seed + i * 7;
        return v[7:0];
    endfunction

    task automatic do_reset();
        i_rst = 1'b1;
        idv = 1'b0; irx_d = '0; irx_er = 1'b0;
        icrc_valid = 1'b0; icrc_ok = 1'b0; ilen_full = 1'b0;
        irel = 1'b0; irel_len = '0;
        repeat (3) @(negedge iclk);
        i_rst = 1'b0;
        @(negedge iclk);
    endtask

    // n_wr bytes are expected in RAM from start_addr; drop_idx marks the byte that triggers a drop.
    task automatic send_pkt(input int len, input int err_at, input int start_addr,
                            input int n_wr, input int drop_idx, input int seed);
        for (int i = 0; i < len; i++) begin
            @(negedge iclk);
            idv    = 1'b1;
            irx_d  = pat(seed, i);
            irx_er = (i == err_at);
            if (i < n_wr) exp_wr_q.push_back({12'((start_addr + i) % 3072), pat(seed, i)});
            if (i == drop_idx) exp_drop_q.push_back(1);
        end
        @(negedge iclk);
        idv    = 1'b0;
        irx_er = 1'b0;
    endtask

    task automatic verdict(input bit ok, input int exp_len, input bit exp_drop, input int rel_len);
        repeat (2) @(negedge iclk);
        icrc_valid = 1'b1;
        icrc_ok    = ok;
        if (exp_len > 0) exp_len_q.push_back(exp_len);
        if (exp_drop) exp_drop_q.push_back(1);
        @(negedge iclk);
        icrc_valid = 1'b0;
        icrc_ok    = 1'b0;
        if (rel_len > 0) begin
            irel     = 1'b1;
            irel_len = 16'(rel_len);
            @(negedge iclk);
            irel = 1'b0;
        end
        repeat (3) @(negedge iclk);
    endtask

    task automatic release_pkt(input int n);
        @(negedge iclk);
        irel     = 1'b1;
        irel_len = 16'(n);
        @(negedge iclk);
        irel = 1'b0;
    endtask

    task automatic settle(input string name, input int exp_used);
        repeat (4) @(negedge iclk);
        check({name, "_wr_pending"}, exp_wr_q.size(), 0);
        check({name, "_len_pending"}, exp_len_q.size(), 0);
        check({name, "_drop_pending"}, exp_drop_q.size(), 0);
        check({name, "_oused"}, int'(oused), exp_used);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        i_rst = 1'b1;
        @(negedge iclk);
        check("rst_ram_we", int'(oram_we), 0);
        check("rst_ram_waddr", int'(oram_waddr), 0);
        check("rst_len_we", int'(olen_we), 0);
        check("rst_drop", int'(odrop), 0);
        check("rst_oused", int'(oused), 0);
        i_rst = 1'b0;

        // 1: 100-byte good packet from empty
        send_pkt(100, -1, 0, 100, -1, 1);
        verdict(1'b1, 100, 1'b0, 0);
        settle("t1", 100);

        // 2: error on byte 50, then an 80-byte packet reuses address 0
        do_reset();
        send_pkt(60, 49, 0, 49, 49, 2);
        settle("t2a", 0);
        send_pkt(80, -1, 0, 80, -1, 3);
        verdict(1'b1, 80, 1'b0, 0);
        settle("t2b", 80);

        // 3: commit point at 3000, next packet wraps through the end of RAM
        do_reset();
        send_pkt(1500, -1, 0, 1500, -1, 4);
        verdict(1'b1, 1500, 1'b0, 0);
        release_pkt(1500);
        send_pkt(1500, -1, 1500, 1500, -1, 5);
        verdict(1'b1, 1500, 1'b0, 0);
        release_pkt(1500);
        settle("t3a", 0);
        send_pkt(100, -1, 3000, 100, -1, 6);
        verdict(1'b1, 100, 1'b0, 0);
        settle("t3b", 100);

        // 4: insufficient space drops, release reopens
        do_reset();
        send_pkt(1000, -1, 0, 1000, -1, 7);
        verdict(1'b1, 1000, 1'b0, 0);
        send_pkt(600, -1, 1000, 600, -1, 8);
        verdict(1'b1, 600, 1'b0, 0);
        settle("t4a", 1600);
        send_pkt(70, -1, 1600, 0, 0, 9);
        settle("t4b", 1600);
        release_pkt(200);
        settle("t4c", 1400);
        send_pkt(100, -1, 1600, 100, -1, 10);
        verdict(1'b1, 100, 1'b0, 0);
        settle("t4d", 1500);

        // 5: oversize, runt, min-size, CRC bad, length FIFO full, idv during WAIT_CRC
        do_reset();
        send_pkt(1537, -1, 0, 1536, 1536, 11);
        settle("t5a", 0);
        send_pkt(40, -1, 0, 40, -1, 12);
        verdict(1'b1, 0, 1'b1, 0);
        settle("t5b", 0);
        send_pkt(64, -1, 0, 64, -1, 13);
        verdict(1'b1, 64, 1'b0, 0);
        settle("t5c", 64);
        send_pkt(100, -1, 64, 100, -1, 14);
        verdict(1'b0, 0, 1'b1, 0);
        settle("t5d", 64);
        ilen_full = 1'b1;
        send_pkt(10, -1, 64, 0, 0, 15);
        ilen_full = 1'b0;
        settle("t5e", 64);
        send_pkt(70, -1, 64, 70, -1, 16);
        send_pkt(20, -1, 64, 0, 0, 17);
        settle("t5f", 64);
        send_pkt(64, -1, 64, 64, -1, 18);
        verdict(1'b1, 64, 1'b0, 0);
        settle("t5g", 128);

        // 6: commit and release in the same cycle
        do_reset();
        send_pkt(500, -1, 0, 500, -1, 19);
        verdict(1'b1, 500, 1'b0, 0);
        settle("t6a", 500);
        send_pkt(64, -1, 500, 64, -1, 20);
        verdict(1'b1, 64, 1'b0, 100);
        settle("t6b", 464);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
